// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

  // Clock cycles per line bit (integer division, remainder dropped).
  function automatic int bit_ticks(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Counter width able to hold n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Synchronous FIFO holding characters waiting to be serialised.
// DEPTH must be a power of two so the pointers wrap on their own.
module uart_tx_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_full  = (count == (AW+1)'(DEPTH));
  assign o_empty = (count == '0);
  assign o_head  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

`ifdef FORMAL
  // The controller must never push into a full or pop from an empty buffer.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!(i_push && o_full));
      assert (!(i_pop && o_empty));
    end
  end
`endif

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO front end, frame FSM and shifter.
// Optional feature macro: UART_TX_PARITY_EN (parity bit after the data bits,
// polarity chosen by i_parity_odd).
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | line high, waiting for the FIFO to become non-empty
// ST_START  | start bit (low) for BIT_TICKS cycles
// ST_DATA   | data bits LSB first, BIT_TICKS cycles each
// ST_PARITY | parity bit (only with UART_TX_PARITY_EN)
// ST_STOP   | STOP_BITS stop bits (high); pops the next entry if present
//
// o_tx is registered from the current state, so the line lags the state by
// one cycle; every bit still lasts exactly BIT_TICKS cycles.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int I_CLOCK_FREQ = 50_000000,
  parameter int BAUD_RATE    = 115200,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_stb,
`ifdef UART_TX_PARITY_EN
  input  logic                 i_parity_odd,
`endif
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy
);

  localparam int BIT_TICKS = bit_ticks(I_CLOCK_FREQ, BAUD_RATE);
  localparam int TICK_W    = cnt_width(BIT_TICKS);
  localparam int IDX_W     = 4;
  localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(BIT_TICKS - 1);
  localparam logic [IDX_W-1:0]  LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_e            state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif
  logic                 rst_done;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 tick_tc;

  // Writes are held off until the first edge after reset release has passed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  // Push/pop qualification and terminal-count decode.
  always_comb begin
    tick_tc = (tick_cnt == '0);
    push    = i_stb && !fifo_full && rst_done;
    pop     = !fifo_empty &&
              ((state == ST_IDLE) ||
               ((state == ST_STOP) && tick_tc && (bit_idx == LAST_STOP)));
  end

  assign o_ready = !fifo_full;
  assign o_busy  = (state != ST_IDLE) || !fifo_empty;

  uart_tx_fifo_mem #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (i_data),
    .i_pop   (pop),
    .o_head  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Frame sequencer: down-counter per bit, registered line output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
      o_tx     <= 1'b1;
    end else begin
      case (state)
        ST_START: o_tx <= 1'b0;
        ST_DATA:  o_tx <= shreg[0];
`ifdef UART_TX_PARITY_EN
        ST_PARITY: o_tx <= par_bit;
`endif
        default:  o_tx <= 1'b1;
      endcase

      case (state)
        ST_IDLE: begin
          if (pop) begin
            shreg    <= fifo_head;
`ifdef UART_TX_PARITY_EN
            par_bit  <= (^fifo_head) ^ i_parity_odd;
`endif
            tick_cnt <= TICK_LOAD;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (tick_tc) begin
            tick_cnt <= TICK_LOAD;
            bit_idx  <= '0;
            state    <= ST_DATA;
          end else begin
            tick_cnt <= tick_cnt - TICK_W'(1);
          end
        end
        ST_DATA: begin
          if (tick_tc) begin
            tick_cnt <= TICK_LOAD;
            shreg    <= shreg >> 1;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= ST_PARITY;
`else
              state   <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            tick_cnt <= tick_cnt - TICK_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick_tc) begin
            tick_cnt <= TICK_LOAD;
            bit_idx  <= '0;
            state    <= ST_STOP;
          end else begin
            tick_cnt <= tick_cnt - TICK_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (tick_tc) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              if (pop) begin
                shreg    <= fifo_head;
`ifdef UART_TX_PARITY_EN
                par_bit  <= (^fifo_head) ^ i_parity_odd;
`endif
                tick_cnt <= TICK_LOAD;
                state    <= ST_START;
              end else begin
                state    <= ST_IDLE;
              end
            end else begin
              tick_cnt <= TICK_LOAD;
              bit_idx  <= bit_idx + IDX_W'(1);
            end
          end else begin
            tick_cnt <= tick_cnt - TICK_W'(1);
          end
        end
        default: begin
          tick_cnt <= '0;
          bit_idx  <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FORMAL
  // Counter range, legal encoding, buffer discipline and idle line level.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (tick_cnt <= TICK_LOAD);
`ifdef UART_TX_PARITY_EN
      assert (state inside {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP});
`else
      assert (state inside {ST_IDLE, ST_START, ST_DATA, ST_STOP});
`endif
      assert (!(push && fifo_full));
      assert (!(pop && fifo_empty));
      if (state == ST_IDLE) assert (o_tx);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: two instances (8N1 depth 4, 7-bit two-stop
// depth 16), both at 10 clock cycles per bit.
module tb_uart_tx_fifo;

  localparam int BT = 10;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst0_n, rst1_n;
  logic [7:0] d0;
  logic [6:0] d1;
  logic       stb0, stb1, par0, par1;
  logic       ready0, tx0, busy0;
  logic       ready1, tx1, busy1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .I_CLOCK_FREQ (50_000_000),
    .BAUD_RATE    (5_000_000),
    .DATA_BITS    (8),
    .STOP_BITS    (1),
    .FIFO_DEPTH   (4)
  ) u_dut0 (
    .i_clk        (clk),
    .i_rst_n      (rst0_n),
    .i_data       (d0),
    .i_stb        (stb0),
`ifdef UART_TX_PARITY_EN
    .i_parity_odd (par0),
`endif
    .o_ready      (ready0),
    .o_tx         (tx0),
    .o_busy       (busy0)
  );

  uart_tx_fifo #(
    .I_CLOCK_FREQ (50_000_000),
    .BAUD_RATE    (5_000_000),
    .DATA_BITS    (7),
    .STOP_BITS    (2),
    .FIFO_DEPTH   (16)
  ) u_dut1 (
    .i_clk        (clk),
    .i_rst_n      (rst1_n),
    .i_data       (d1),
    .i_stb        (stb1),
`ifdef UART_TX_PARITY_EN
    .i_parity_odd (par1),
`endif
    .o_ready      (ready1),
    .o_tx         (tx1),
    .o_busy       (busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input int dut);
    return (dut == 1) ? tx1 : tx0;
  endfunction

  // Entered at the negedge showing the first start-bit cycle; leaves one
  // negedge after the last stop cycle.
  task automatic expect_frame(input int dut, input logic [8:0] data, input int nbits,
                              input int nstop, input logic par_odd, input string tag);
    logic seq [16];
    logic p;
    int   n;
    n = 0;
    p = par_odd;
    seq[n] = 1'b0; n++;
    for (int i = 0; i < nbits; i++) begin
      seq[n] = data[i]; n++;
      p = p ^ data[i];
    end
    if (PAR_EN) begin
      seq[n] = p; n++;
    end
    for (int i = 0; i < nstop; i++) begin
      seq[n] = 1'b1; n++;
    end
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < BT; c++) begin
        chk($sformatf("%s bit%0d cyc%0d", tag, b, c), tx_of(dut), seq[b]);
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_start(input int dut, input int max, input string tag);
    int k;
    k = 0;
    while (tx_of(dut) !== 1'b0 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " start seen"}, tx_of(dut), 1'b0);
  endtask

  task automatic watch_quiet(input int dut, input int cycles, input string tag);
    int falls;
    falls = 0;
    for (int i = 0; i < cycles; i++) begin
      if (tx_of(dut) == 1'b0) falls++;
      @(negedge clk);
    end
    chk({tag, " line quiet"}, falls, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ready_exp [6];
    logic [7:0] v;
    ready_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst0_n = 1'b0; rst1_n = 1'b0;
    d0 = '0; d1 = '0; stb0 = 1'b0; stb1 = 1'b0; par0 = 1'b0; par1 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst tx0", tx0, 1'b1);
    chk("rst ready0", ready0, 1'b1);
    chk("rst busy0", busy0, 1'b0);
    chk("rst tx1", tx1, 1'b1);
    chk("rst busy1", busy1, 1'b0);

    // Write presented across reset release must be ignored
    d0 = 8'h3C; stb0 = 1'b1;
    rst0_n = 1'b1; rst1_n = 1'b1;
    @(negedge clk);
    stb0 = 1'b0;
    chk("release write ignored busy", busy0, 1'b0);
    @(negedge clk);
    chk("release write ignored tx", tx0, 1'b1);
    watch_quiet(0, 20, "release");

    // Single 0xA5: latency, bit order, stop, busy drop
    d0 = 8'hA5; stb0 = 1'b1;
    @(negedge clk);
    stb0 = 1'b0; d0 = 8'h00;
    chk("a5 tx after write", tx0, 1'b1);
    chk("a5 busy after write", busy0, 1'b1);
    @(negedge clk);
    chk("a5 tx one edge later", tx0, 1'b1);
    par0 = 1'b1;
    @(negedge clk);
    expect_frame(0, 9'h0A5, 8, 1, 1'b0, "a5");
    par0 = 1'b0;
    chk("a5 busy after frame", busy0, 1'b0);
    chk("a5 tx idle", tx0, 1'b1);

    // Back-to-back 0x00, 0xFF, 0x55
    fork
      begin
        d0 = 8'h00; stb0 = 1'b1;
        @(negedge clk);
        d0 = 8'hFF;
        @(negedge clk);
        d0 = 8'h55;
        @(negedge clk);
        stb0 = 1'b0;
      end
      begin
        wait_start(0, 10, "b2b");
        expect_frame(0, 9'h000, 8, 1, 1'b0, "b2b 00");
        expect_frame(0, 9'h0FF, 8, 1, 1'b0, "b2b ff");
        expect_frame(0, 9'h055, 8, 1, 1'b0, "b2b 55");
        chk("b2b busy end", busy0, 1'b0);
      end
    join
    watch_quiet(0, 15, "b2b");

    // Depth-4 overflow: six writes, fifth fits after the first pop, sixth dropped
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          v = 8'h11 * 8'(i + 1);
          d0 = v; stb0 = 1'b1;
          @(negedge clk);
          chk($sformatf("ovf ready after write %0d", i), ready0, ready_exp[i]);
        end
        stb0 = 1'b0;
      end
      begin
        wait_start(0, 10, "ovf");
        expect_frame(0, 9'h011, 8, 1, 1'b0, "ovf 11");
        expect_frame(0, 9'h022, 8, 1, 1'b0, "ovf 22");
        expect_frame(0, 9'h033, 8, 1, 1'b0, "ovf 33");
        expect_frame(0, 9'h044, 8, 1, 1'b0, "ovf 44");
        expect_frame(0, 9'h055, 8, 1, 1'b0, "ovf 55");
        chk("ovf busy end", busy0, 1'b0);
        watch_quiet(0, 40, "ovf no sixth");
      end
    join

`ifdef UART_TX_PARITY_EN
    // 0x07: even parity -> 1, odd parity -> 0
    par0 = 1'b0; d0 = 8'h07; stb0 = 1'b1;
    @(negedge clk);
    stb0 = 1'b0;
    wait_start(0, 10, "par even");
    expect_frame(0, 9'h007, 8, 1, 1'b0, "par even");
    chk("par even busy", busy0, 1'b0);
    par0 = 1'b1; d0 = 8'h07; stb0 = 1'b1;
    @(negedge clk);
    stb0 = 1'b0;
    wait_start(0, 10, "par odd");
    expect_frame(0, 9'h007, 8, 1, 1'b1, "par odd");
    chk("par odd busy", busy0, 1'b0);
    par0 = 1'b0;
`endif

    // Reset mid-DATA with two characters still queued
    fork
      begin
        d0 = 8'hC3; stb0 = 1'b1;
        @(negedge clk);
        d0 = 8'h3C;
        @(negedge clk);
        d0 = 8'h99;
        @(negedge clk);
        stb0 = 1'b0;
      end
      begin
        wait_start(0, 10, "abort");
      end
    join
    repeat (12) @(negedge clk);
    chk("abort busy before reset", busy0, 1'b1);
    #2;
    rst0_n = 1'b0;
    #1;
    chk("abort tx async", tx0, 1'b1);
    chk("abort busy async", busy0, 1'b0);
    chk("abort ready async", ready0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst0_n = 1'b1;
    @(negedge clk);
    watch_quiet(0, 150, "abort after release");
    chk("abort busy after release", busy1, 1'b0);
    chk("abort busy0 after release", busy0, 1'b0);

    // 7 data bits, 2 stop bits: 0x41
    d1 = 7'h41; stb1 = 1'b1;
    @(negedge clk);
    stb1 = 1'b0;
    chk("d7s2 tx after write", tx1, 1'b1);
    @(negedge clk);
    chk("d7s2 tx one edge later", tx1, 1'b1);
    @(negedge clk);
    expect_frame(1, 9'h041, 7, 2, 1'b0, "d7s2");
    chk("d7s2 busy end", busy1, 1'b0);
    chk("d7s2 tx idle", tx1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter I_CLOCK_FREQ, default 50_000000: input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200: line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal 5..9.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: transmit buffer entries, power of 2, at least 2.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-007 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port i_data, input, DATA_BITS wide: character to enqueue.
REQ-009 SHALL have port i_stb, input, 1 bit: enqueue request, qualified by o_ready.
REQ-010 SHALL have port o_ready, output, 1 bit: FIFO not full.
REQ-011 SHALL have port o_tx, output, 1 bit: registered serial line, idle high.
REQ-012 SHALL have port o_busy, output, 1 bit: FIFO non-empty or frame in progress.
REQ-013 SHALL have port i_parity_odd, input, 1 bit, present only with UART_TX_PARITY_EN: 1 = odd parity, 0 = even.

Function
REQ-014 SHALL define BIT_TICKS = I_CLOCK_FREQ/BAUD_RATE (integer division); every line bit lasts exactly BIT_TICKS cycles.
REQ-015 SHALL accept a write on any edge where i_stb && o_ready; i_stb while full is dropped, with no state change.
REQ-016 SHALL keep o_ready low exactly when the FIFO holds FIFO_DEPTH entries; pointers wrap modulo FIFO_DEPTH.
REQ-017 SHALL run the FSM through IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
REQ-018 SHALL, in IDLE with the FIFO non-empty, pop the head entry into the shift register and enter START on the same edge.
REQ-019 SHALL drive o_tx low in START, DATA LSB first in DATA (bit index 0..DATA_BITS-1), and high in STOP for STOP_BITS*BIT_TICKS cycles.
REQ-020 SHALL have o_tx fall on the second rising edge after the edge that writes a byte into an empty FIFO while the FSM is IDLE.
REQ-021 SHALL, at the end of STOP with the FIFO non-empty, pop and enter START directly, with no idle cycle between frames.
REQ-022 SHALL allow a write and a pop on the same edge; occupancy is then unchanged.
REQ-023 SHALL ignore later changes on i_data and i_parity_odd for a character after it has been captured.
REQ-024 SHALL hold the bit counter at or below BIT_TICKS-1 and the FSM in a legal state at all times.

Reset
REQ-025 SHALL, while i_rst_n is low, force the FSM to IDLE, empty the FIFO, clear the counters, and set o_tx=1, o_ready=1, o_busy=0, all asynchronously.
REQ-026 SHALL abort any frame in progress on reset, with o_tx returning high immediately, and SHALL discard all queued data.
REQ-027 SHALL release reset synchronously to i_clk, accepting no write on the edge where i_rst_n rises.

Configuration
REQ-028 SHALL use macro UART_TX_PARITY_EN; when defined, insert one PARITY bit after DATA = XOR of the data bits, inverted when i_parity_odd is 1, sampled at pop.
REQ-029 SHALL, when UART_TX_PARITY_EN is undefined, omit port i_parity_odd and the PARITY state; the frame is START+DATA+STOP only.

Structure
REQ-030 SHALL place the FSM state enum and the BIT_TICKS function in package uart_pkg.
REQ-031 SHALL implement the buffer as sub-module uart_tx_fifo_mem (sync FIFO: push/pop/full/empty/head data); the FSM and shifter stay in the top.
REQ-032 SHALL, under FORMAL, assert REQ-024, no write while full, no pop while empty, and o_tx==1 in IDLE.

Verification (I_CLOCK_FREQ=50_000000, BAUD_RATE=5_000000, BIT_TICKS=10)
REQ-033 SHALL check: write 0xA5 into an idle design -> o_tx low 2 edges later, then bits 1,0,1,0,0,1,0,1 for 10 cycles each, then high 10 cycles, o_busy=0 after.
REQ-034 SHALL check: 3 back-to-back writes 0x00,0xFF,0x55 -> three frames with no idle gap, stop-to-start exactly 10 cycles.
REQ-035 SHALL check: FIFO_DEPTH=4 with 6 writes in consecutive cycles -> o_ready low after 4 accepted (the 5th is accepted once the first pop frees a slot), the 6th dropped, exactly 5 frames sent.
REQ-036 SHALL check: with UART_TX_PARITY_EN, 0x07 and i_parity_odd=0 -> parity bit 1; i_parity_odd=1 -> parity bit 0; frame 110 cycles.
REQ-037 SHALL check: i_rst_n low mid-DATA with 2 entries queued -> o_tx=1 and o_busy=0 asynchronously, no further frames after release.
REQ-038 SHALL check: DATA_BITS=7, STOP_BITS=2, write 0x41 -> frame 100 cycles, final 20 cycles high.
